prim_membridge: RTL and testbench

//   Bus bridge between the Prim CPU data/instruction port and an 8-bit asynchronous SRAM.

---
 rtl/prim_membridge.sv | 210 +++++++++++++++++++++
 tb/tb_prim_membridge.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/prim_membridge.sv
// prim_membridge
//   Bridges one Prim CPU request (16-bit byte address, byte select, write
//   enable) onto an 8-bit asynchronous SRAM as one or two byte phases.
//   Little-endian: low byte at A, high byte at A+1 (address wraps at FFFF).
//   Each byte phase lasts WAIT_STATES+1 cycles. A one-cycle o_ack pulse
//   marks completion. o_dat is registered and holds until the next read.
//
// Ports
//   i_clk, i_reset       clock, asynchronous active-high reset
//   i_addr, i_dat        CPU byte address / write data (sampled in IDLE only)
//   i_bs, i_we           byte select (00 none, 01 lo, 11 word, 10 hi), write
//   o_dat, o_ack         read data to CPU, access-complete pulse
//   o_mem_addr/dat       SRAM address / write data
//   i_mem_dat            SRAM read data
//   o_mem_ce/oe/we       SRAM strobes, active-high
//   i_mem_wait           optional SRAM wait input (see below)
//
// Configuration
//   PRIM_MEMBRIDGE_WAITIN_EN  adds i_mem_wait: once the wait counter has
//   expired, a LO/HI phase extends while i_mem_wait=1. Without the macro the
//   phase timing is fixed by WAIT_STATES.
//
// state | meaning
// IDLE  | waiting for i_bs != 0, latches the request
// LO    | byte phase at A
// GAP   | turnaround between LO and HI of a word, strobes low
// HI    | byte phase at A+1
// ACK   | o_ack high for one cycle, strobes low

module prim_membridge #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_dat,
  output logic [15:0] o_dat,
  input  logic [1:0]  i_bs,
  input  logic        i_we,
  output logic        o_ack,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_dat,
  input  logic [7:0]  i_mem_dat,
`ifdef PRIM_MEMBRIDGE_WAITIN_EN
  input  logic        i_mem_wait,
`endif
  output logic        o_mem_ce,
  output logic        o_mem_oe,
  output logic        o_mem_we
);

  typedef enum logic [2:0] {S_IDLE, S_LO, S_GAP, S_HI, S_ACK} state_e;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] dat_q, dat_d;
  logic [1:0]  bs_q, bs_d;
  logic        req_we_q, req_we_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [15:0] rdat_q, rdat_d;
  logic        ack_q, ack_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_dat_q, mem_dat_d;
  logic        ce_q, ce_d;
  logic        oe_q, oe_d;
  logic        mem_we_q, mem_we_d;

  logic mem_wait;
`ifdef PRIM_MEMBRIDGE_WAITIN_EN
  assign mem_wait = i_mem_wait;
`else
  assign mem_wait = 1'b0;
`endif

  // A phase ends on the cycle where the counter has reached zero and the
  // SRAM is not holding us off; read data is captured on that same cycle.
  logic phase_done;
  assign phase_done = (wcnt_q == 4'd0) && !mem_wait;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    dat_d      = dat_q;
    bs_d       = bs_q;
    req_we_d   = req_we_q;
    wcnt_d     = wcnt_q;
    rdat_d     = rdat_q;
    ack_d      = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_dat_d  = mem_dat_q;
    ce_d       = ce_q;
    oe_d       = oe_q;
    mem_we_d   = mem_we_q;

    case (state_q)
      S_IDLE: begin
        if (i_bs != 2'b00) begin
          addr_d   = i_addr;
          dat_d    = i_dat;
          bs_d     = i_bs;
          req_we_d = i_we;
          wcnt_d   = WS;
          ce_d     = 1'b1;
          oe_d     = ~i_we;
          mem_we_d = i_we;
          if (i_bs == 2'b10) begin
            state_d    = S_HI;
            mem_addr_d = i_addr + 16'd1;
            mem_dat_d  = i_dat[15:8];
          end else begin
            state_d    = S_LO;
            mem_addr_d = i_addr;
            mem_dat_d  = i_dat[7:0];
          end
        end
      end
      S_LO: begin
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else if (phase_done) begin
          if (!req_we_q)
            rdat_d = {(bs_q == 2'b11) ? rdat_q[15:8] : 8'h00, i_mem_dat};
          ce_d     = 1'b0;
          oe_d     = 1'b0;
          mem_we_d = 1'b0;
          if (bs_q == 2'b11) begin
            state_d    = S_GAP;
            mem_addr_d = addr_q + 16'd1;
          end else begin
            state_d = S_ACK;
            ack_d   = 1'b1;
          end
        end
      end
      S_GAP: begin
        state_d   = S_HI;
        wcnt_d    = WS;
        ce_d      = 1'b1;
        oe_d      = ~req_we_q;
        mem_we_d  = req_we_q;
        mem_dat_d = dat_q[15:8];
      end
      S_HI: begin
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else if (phase_done) begin
          if (!req_we_q)
            rdat_d = {i_mem_dat, (bs_q == 2'b11) ? rdat_q[7:0] : 8'h00};
          ce_d     = 1'b0;
          oe_d     = 1'b0;
          mem_we_d = 1'b0;
          state_d  = S_ACK;
          ack_d    = 1'b1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        ce_d     = 1'b0;
        oe_d     = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      dat_q      <= '0;
      bs_q       <= '0;
      req_we_q   <= 1'b0;
      wcnt_q     <= '0;
      rdat_q     <= '0;
      ack_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_dat_q  <= '0;
      ce_q       <= 1'b0;
      oe_q       <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      dat_q      <= dat_d;
      bs_q       <= bs_d;
      req_we_q   <= req_we_d;
      wcnt_q     <= wcnt_d;
      rdat_q     <= rdat_d;
      ack_q      <= ack_d;
      mem_addr_q <= mem_addr_d;
      mem_dat_q  <= mem_dat_d;
      ce_q       <= ce_d;
      oe_q       <= oe_d;
      mem_we_q   <= mem_we_d;
    end
  end

  assign o_dat      = rdat_q;
  assign o_ack      = ack_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_dat  = mem_dat_q;
  assign o_mem_ce   = ce_q;
  assign o_mem_oe   = oe_q;
  assign o_mem_we   = mem_we_q;

endmodule

// File: tb/tb_prim_membridge.sv
// Directed bench for prim_membridge (WAIT_STATES=1) with a behavioural SRAM.
// When PRIM_MEMBRIDGE_WAITIN_EN is defined a second instance (WAIT_STATES=0)
// exercises the i_mem_wait extension.

module tb_prim_membridge;

  logic        clk;
  logic        rst;
  logic [15:0] i_addr;
  logic [15:0] i_dat;
  logic [15:0] o_dat;
  logic [1:0]  i_bs;
  logic        i_we;
  logic        o_ack;
  logic [15:0] o_mem_addr;
  logic [7:0]  o_mem_dat;
  logic [7:0]  i_mem_dat;
  logic        o_mem_ce;
  logic        o_mem_oe;
  logic        o_mem_we;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [0:65535];
  logic ce_hist [0:63];
  logic oe_hist [0:63];
  logic we_hist [0:63];

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PRIM_MEMBRIDGE_WAITIN_EN
  logic        i_mem_wait;
  logic [15:0] w_addr, w_dat, w_odat, w_maddr;
  logic [1:0]  w_bs;
  logic        w_we, w_ack, w_ce, w_oe, w_mwe, w_wait;
  logic [7:0]  w_mdat, w_imdat;
  assign i_mem_wait = 1'b0;
  // Data is only valid once wait drops; capturing early would give EE.
  assign w_imdat = (w_ce && w_oe) ? (w_wait ? 8'hEE : 8'h5A) : 8'h00;
`endif

  prim_membridge #(.WAIT_STATES(1)) u_dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_addr     (i_addr),
    .i_dat      (i_dat),
    .o_dat      (o_dat),
    .i_bs       (i_bs),
    .i_we       (i_we),
    .o_ack      (o_ack),
    .o_mem_addr (o_mem_addr),
    .o_mem_dat  (o_mem_dat),
    .i_mem_dat  (i_mem_dat),
`ifdef PRIM_MEMBRIDGE_WAITIN_EN
    .i_mem_wait (i_mem_wait),
`endif
    .o_mem_ce   (o_mem_ce),
    .o_mem_oe   (o_mem_oe),
    .o_mem_we   (o_mem_we)
  );

`ifdef PRIM_MEMBRIDGE_WAITIN_EN
  prim_membridge #(.WAIT_STATES(0)) u_dut_w (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_addr     (w_addr),
    .i_dat      (w_dat),
    .o_dat      (w_odat),
    .i_bs       (w_bs),
    .i_we       (w_we),
    .o_ack      (w_ack),
    .o_mem_addr (w_maddr),
    .o_mem_dat  (w_mdat),
    .i_mem_dat  (w_imdat),
    .i_mem_wait (w_wait),
    .o_mem_ce   (w_ce),
    .o_mem_oe   (w_oe),
    .o_mem_we   (w_mwe)
  );
`endif

  assign i_mem_dat = (o_mem_ce && o_mem_oe) ? mem[o_mem_addr] : 8'h00;

  always @(posedge clk)
    if (o_mem_ce && o_mem_we) mem[o_mem_addr] <= o_mem_dat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one request at a negedge (cycle 0); drops it after IDLE has
  // sampled it. Returns the cycle number where o_ack was seen, or -1.
  task automatic do_access(input logic [1:0] bs, input logic we, input logic [15:0] a,
                           input logic [15:0] d, output int ack_at);
    @(negedge clk);
    i_bs = bs; i_we = we; i_addr = a; i_dat = d;
    ack_at = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      i_bs = 2'b00; i_we = 1'b0; i_addr = 16'h0; i_dat = 16'h0;
      ce_hist[n] = o_mem_ce; oe_hist[n] = o_mem_oe; we_hist[n] = o_mem_we;
      if (o_ack) begin
        ack_at = n;
        break;
      end
    end
  endtask

  initial begin
    int ack_at;
    int cnt;
    int ack1, ack2, nacks;
    bit adjacent;
    logic prev_ack;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h77;
    mem[16'h0010] = 8'h34;
    mem[16'h0011] = 8'h12;
    mem[16'h0005] = 8'h55;

    rst = 1'b1; i_bs = 2'b00; i_we = 1'b0; i_addr = 16'h0; i_dat = 16'h0;
`ifdef PRIM_MEMBRIDGE_WAITIN_EN
    w_bs = 2'b00; w_we = 1'b0; w_addr = 16'h0; w_dat = 16'h0; w_wait = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ack", o_ack, 1'b0);
    chk("reset_dat", o_dat, 16'h0000);
    chk("reset_strobes", {o_mem_ce, o_mem_oe, o_mem_we}, 3'b000);
    chk("reset_addr", o_mem_addr, 16'h0000);
    chk("reset_mdat", o_mem_dat, 8'h00);

    // word read, WAIT_STATES=1: LO 1-2, GAP 3, HI 4-5, ACK 6
    do_access(2'b11, 1'b0, 16'h0010, 16'h0, ack_at);
    chk("wrd_rd_ack_cycle", ack_at, 6);
    chk("wrd_rd_dat", o_dat, 16'h1234);
    chk("wrd_rd_lo_ce_oe", {ce_hist[1], oe_hist[1], ce_hist[2]}, 3'b111);
    chk("wrd_rd_gap_ce", ce_hist[3], 1'b0);
    chk("wrd_rd_hi_ce", {ce_hist[4], ce_hist[5]}, 2'b11);

    // byte write: one 2-cycle we phase, ack at 3
    do_access(2'b01, 1'b1, 16'h0020, 16'hABCD, ack_at);
    chk("byte_wr_ack_cycle", ack_at, 3);
    cnt = 0;
    for (int n = 1; n <= 3; n++) if (we_hist[n]) cnt++;
    chk("byte_wr_we_cycles", cnt, 2);
    chk("byte_wr_mem20", mem[16'h0020], 8'hCD);
    chk("byte_wr_mem21", mem[16'h0021], 8'h77);
    chk("byte_wr_dat_kept", o_dat, 16'h1234);

    do_access(2'b01, 1'b0, 16'h0020, 16'h0, ack_at);
    chk("byte_rd_ack_cycle", ack_at, 3);
    chk("byte_rd_dat", o_dat, 16'h00CD);

    // word write across the top of the address space
    do_access(2'b11, 1'b1, 16'hFFFF, 16'hBEEF, ack_at);
    chk("wrap_wr_ack_cycle", ack_at, 6);
    chk("wrap_wr_memFFFF", mem[16'hFFFF], 8'hEF);
    chk("wrap_wr_mem0000", mem[16'h0000], 8'hBE);

    // high-byte read at FFFF targets 0000
    do_access(2'b10, 1'b0, 16'hFFFF, 16'h0, ack_at);
    chk("hi_rd_ack_cycle", ack_at, 3);
    chk("hi_rd_dat", o_dat, 16'hBE00);

    // back-to-back: request held; acks expected at cycles 3 and 7
    @(negedge clk);
    i_bs = 2'b01; i_we = 1'b0; i_addr = 16'h0005;
    ack1 = -1; ack2 = -1; nacks = 0; adjacent = 1'b0; prev_ack = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 8) i_bs = 2'b00;
      if (o_ack) begin
        nacks++;
        if (ack1 < 0) ack1 = n; else if (ack2 < 0) ack2 = n;
        if (prev_ack) adjacent = 1'b1;
      end
      prev_ack = o_ack;
    end
    chk("b2b_ack_count", nacks, 2);
    chk("b2b_first_ack", ack1, 3);
    chk("b2b_second_ack", ack2, 7);
    chk("b2b_adjacent", adjacent, 1'b0);
    chk("b2b_dat", o_dat, 16'h0055);

    // reset in the middle of a word read
    @(negedge clk);
    i_bs = 2'b11; i_we = 1'b0; i_addr = 16'h0010;
    @(negedge clk);
    i_bs = 2'b00;
    @(negedge clk);
    chk("rst_mid_ce_before", {o_mem_ce, o_mem_oe}, 2'b11);
    rst = 1'b1;
    #1;
    chk("rst_mid_strobes", {o_mem_ce, o_mem_oe, o_mem_we, o_ack}, 4'b0000);
    chk("rst_mid_dat", o_dat, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (o_ack || o_mem_ce) cnt++;
    end
    chk("rst_mid_no_ack", cnt, 0);

`ifdef PRIM_MEMBRIDGE_WAITIN_EN
    // WAIT_STATES=0, wait high for LO cycles 1-3 -> LO 1-4, ACK 5
    @(negedge clk);
    w_bs = 2'b01; w_we = 1'b0; w_addr = 16'h0100; w_wait = 1'b1;
    ack_at = -1; cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      w_bs = 2'b00;
      if (n == 4) w_wait = 1'b0;
      if (w_ce) cnt++;
      if (w_ack) begin
        ack_at = n;
        break;
      end
    end
    chk("waitin_ack_cycle", ack_at, 5);
    chk("waitin_lo_cycles", cnt, 4);
    chk("waitin_dat", w_odat, 16'h005A);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
